// File: rtl/platform_nios_cpu_debug_host_scan.sv
// Virtual-JTAG host scan engine: turns one command into a UIR/CDR/SDR/UDR/RTI
// sequence on a divided tck and returns the captured DR word and IR status.
module platform_nios_cpu_debug_host_scan #(
    parameter int TCK_DIV  = 2,
    parameter int SR_WIDTH = 38
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic [1:0]          ir_in,
    input  logic                tdo,
    input  logic [1:0]          ir_out
);

    localparam int CNT_W = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
    localparam logic [7:0]       DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_DONE
    } state_t;

    state_t              state;
    logic [7:0]          div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SR_WIDTH-1:0] data_sr;
    logic                active;
    logic                tick;
    logic                rise;
    logic                fall;
    logic                accept;
    logic                sdr_fall;

    // tck only runs in the five scan states; rise/fall mark the clk on which tck toggles.
    assign active   = (state == S_UIR) || (state == S_CDR) || (state == S_SDR) ||
                      (state == S_UDR) || (state == S_RTI);
    assign tick     = active && (div_cnt == DIV_LAST);
    assign rise     = tick && !tck;
    assign fall     = tick && tck;
    assign sdr_fall = (state == S_SDR) && fall;

    assign cmd_ready = reset_n && (state == S_IDLE) && !rsp_valid;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= '0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_ir_out     <= '0;
        end else begin
            if (active) begin
                if (tick) begin
                    div_cnt <= '0;
                    tck     <= ~tck;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_UIR;
                        ir_in   <= cmd_ir;
                        vs_uir  <= 1'b1;
                        div_cnt <= '0;
                        tck     <= 1'b0;
                    end
                end
                S_UIR: begin
                    if (rise) rsp_ir_out <= ir_out;
                    if (fall) begin
                        state  <= S_CDR;
                        vs_uir <= 1'b0;
                        vs_cdr <= 1'b1;
                    end
                end
                S_CDR: begin
                    if (fall) begin
                        state   <= S_SDR;
                        vs_cdr  <= 1'b0;
                        vs_sdr  <= 1'b1;
                        tdi     <= data_sr[0];
                        bit_cnt <= '0;
                    end
                end
                S_SDR: begin
                    // Capture on rise into the MSB so the first bit ends up in bit 0.
                    if (rise) rsp_data <= {tdo, rsp_data[SR_WIDTH-1:1]};
                    if (fall) begin
                        if (bit_cnt == BIT_LAST) begin
                            state   <= S_UDR;
                            vs_sdr  <= 1'b0;
                            vs_udr  <= 1'b1;
                            tdi     <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tdi     <= data_sr[1];
                        end
                    end
                end
                S_UDR: begin
                    if (fall) begin
                        state          <= S_RTI;
                        vs_udr         <= 1'b0;
                        jtag_state_rti <= 1'b1;
                    end
                end
                S_RTI: begin
                    if (fall) begin
                        state          <= S_DONE;
                        jtag_state_rti <= 1'b0;
                        ir_in          <= '0;
                        rsp_valid      <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outgoing DR word; bit 0 is always the next bit to present on tdi.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_sr <= cmd_data;
        end else if (sdr_fall) begin
            data_sr <= data_sr >> 1;
        end
    end

endmodule

// File: tb/tb_platform_nios_cpu_debug_host_scan.sv
// Bench for the virtual-JTAG host scan engine: TCK_DIV=2 and TCK_DIV=1 instances
// checked cycle by cycle against a timing/data model derived from the scan rules.
module tb_platform_nios_cpu_debug_host_scan;

    localparam int SR = 38;

    logic clk = 1'b0;
    logic reset_n;

    logic [1:0]    cmd_valid;
    logic [1:0]    rsp_ready;
    logic [1:0]    tdo;
    logic [1:0]    cmd_ir   [2];
    logic [SR-1:0] cmd_data [2];
    logic [1:0]    ir_out   [2];

    wire [1:0]    cmd_ready, rsp_valid, tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, rti;
    wire [1:0]    rsp_ir_out [2];
    wire [1:0]    ir_in      [2];
    wire [SR-1:0] rsp_data   [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_rsp [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    platform_nios_cpu_debug_host_scan #(.TCK_DIV(2), .SR_WIDTH(SR)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_ir(cmd_ir[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_ir_out(rsp_ir_out[0]),
        .tck(tck[0]), .tdi(tdi[0]), .vs_uir(vs_uir[0]), .vs_cdr(vs_cdr[0]), .vs_sdr(vs_sdr[0]),
        .vs_udr(vs_udr[0]), .jtag_state_rti(rti[0]), .ir_in(ir_in[0]), .tdo(tdo[0]), .ir_out(ir_out[0])
    );

    platform_nios_cpu_debug_host_scan #(.TCK_DIV(1), .SR_WIDTH(SR)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_ir(cmd_ir[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_ir_out(rsp_ir_out[1]),
        .tck(tck[1]), .tdi(tdi[1]), .vs_uir(vs_uir[1]), .vs_cdr(vs_cdr[1]), .vs_sdr(vs_sdr[1]),
        .vs_udr(vs_udr[1]), .jtag_state_rti(rti[1]), .ir_in(ir_in[1]), .tdo(tdo[1]), .ir_out(ir_out[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] obs_vec(input int u);
        return {tck[u], vs_uir[u], vs_cdr[u], vs_sdr[u], vs_udr[u], rti[u],
                tdi[u], ir_in[u], rsp_valid[u], cmd_ready[u]};
    endfunction

    function automatic logic [SR-1:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[SR-1:0];
    endfunction

    // Protocol monitor: strobe exclusivity, tdi moves only with a tck fall, tck quiet when idle.
    logic [1:0] prev_tck = '0;
    logic [1:0] prev_tdi = '0;
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (reset_n === 1'b1) begin
                check("vs_onehot0", 64'($onehot0({vs_uir[u], vs_cdr[u], vs_sdr[u], vs_udr[u], rti[u]})), 64'd1);
                if (tdi[u] !== prev_tdi[u]) check("tdi_on_fall", 64'({prev_tck[u], tck[u]}), 64'd2);
                if (cmd_ready[u]) check("idle_tck", 64'(tck[u]), 64'd0);
            end
        end
        prev_tck <= tck;
        prev_tdi <= tdi;
    end

    // tdo_mode: 0 random, 1 loopback (tdo=tdi), 2 tied high. ir_fix < 0 means random ir_out.
    task automatic run_scan(input int u, input logic [1:0] ir, input logic [SR-1:0] data,
                            input int tdo_mode, input int ir_fix, input int hold,
                            input int abort_at, input bit chk_gap);
        int td, p, nn, acc, sdr_cnt, rv_first, wait_n, idx;
        logic [SR-1:0] exp_data;
        logic [1:0]    exp_ir;
        logic [10:0]   expv;
        logic          tdo_at [0:511];
        logic [1:0]    ir_at  [0:511];

        td = (u == 0) ? 2 : 1;
        p  = 2 * td;
        nn = (4 + SR) * p;
        exp_data = '0;
        exp_ir   = '0;

        wait_n = 0;
        while (!cmd_ready[u] && wait_n < 20) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("ready_before_cmd", 64'(cmd_ready[u]), 64'd1);
        if (!cmd_ready[u]) return;

        cmd_valid[u] = 1'b1;
        cmd_ir[u]    = ir;
        cmd_data[u]  = data;
        @(posedge clk); #1;
        acc = cyc;
        if (chk_gap) check("b2b_accept_gap", 64'(acc - last_rsp[u]), 64'd2);

        sdr_cnt  = 0;
        rv_first = -1;
        for (int n = 0; n <= nn + hold + 1; n++) begin
            idx  = n / p;
            expv = '0;
            if (n < nn) begin
                expv[10]  = 1'((n / td) % 2);
                expv[9]   = (idx == 0);
                expv[8]   = (idx == 1);
                expv[7]   = (idx >= 2) && (idx < SR + 2);
                expv[6]   = (idx == SR + 2);
                expv[5]   = (idx == SR + 3);
                expv[4]   = ((idx >= 2) && (idx < SR + 2)) ? data[idx-2] : 1'b0;
                expv[3:2] = ir;
            end
            expv[1] = (n >= nn) && (n <= nn + hold);
            expv[0] = (n == nn + hold + 1);
            check("cycle_outputs", 64'(obs_vec(u)), 64'(expv));
            if (vs_sdr[u]) sdr_cnt++;
            if (rsp_valid[u] && rv_first < 0) rv_first = n;

            if (n == abort_at) begin
                cmd_valid[u] = 1'b0;
                reset_n = 1'b0;
                #1;
                check("abort_outputs", 64'(obs_vec(u)), 64'd0);
                check("abort_rsp_data", 64'(rsp_data[u]), 64'd0);
                check("abort_rsp_ir", 64'(rsp_ir_out[u]), 64'd0);
                @(posedge clk); @(posedge clk); #1;
                reset_n = 1'b1;
                #1;
                check("abort_ready", 64'(cmd_ready[u]), 64'd1);
                for (int k = 0; k < 12 * p; k++) begin
                    @(posedge clk); #1;
                    check("after_abort", 64'(obs_vec(u)), 64'd1);
                end
                return;
            end

            if (n == nn) begin
                for (int i = 0; i < SR; i++)
                    exp_data[i] = (tdo_mode == 1) ? data[i] : tdo_at[(5 + 2 * i) * td - 1];
                exp_ir = (ir_fix >= 0) ? 2'(ir_fix) : ir_at[td-1];
            end
            if (n >= nn && n <= nn + hold) begin
                check("rsp_data", 64'(rsp_data[u]), 64'(exp_data));
                check("rsp_ir_out", 64'(rsp_ir_out[u]), 64'(exp_ir));
            end

            if (n == nn + hold + 1) begin
                cmd_valid[u] = 1'b0;
            end else begin
                case (tdo_mode)
                    0:       tdo[u] = 1'($urandom);
                    1:       tdo[u] = tdi[u];
                    default: tdo[u] = 1'b1;
                endcase
                tdo_at[n]    = tdo[u];
                ir_out[u]    = (ir_fix >= 0) ? 2'(ir_fix) : 2'($urandom);
                ir_at[n]     = ir_out[u];
                cmd_valid[u] = (n >= nn) ? 1'b1 : 1'($urandom);
                cmd_ir[u]    = 2'($urandom);
                cmd_data[u]  = rand_word();
                rsp_ready[u] = (n >= nn + hold) ? 1'b1 : ((n < nn) ? 1'($urandom) : 1'b0);
                @(posedge clk); #1;
            end
        end
        check("accept_to_rsp", 64'(rv_first), 64'(nn));
        check("vs_sdr_cycles", 64'(sdr_cnt), 64'(SR * p));
        last_rsp[u] = acc + nn;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = '0;
        rsp_ready = '0;
        tdo       = '0;
        for (int u = 0; u < 2; u++) begin
            cmd_ir[u]   = '0;
            cmd_data[u] = '0;
            ir_out[u]   = '0;
            last_rsp[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("reset_outputs", 64'(obs_vec(u)), 64'd0);
            check("reset_rsp_data", 64'(rsp_data[u]), 64'd0);
            check("reset_rsp_ir", 64'(rsp_ir_out[u]), 64'd0);
        end
        reset_n = 1'b1;
        #1;
        check("ready_after_reset0", 64'(cmd_ready[0]), 64'd1);
        check("ready_after_reset1", 64'(cmd_ready[1]), 64'd1);

        // Loopback with the reference pattern.
        run_scan(0, 2'b01, 38'h15_5555_5555, 1, -1, 0, -1, 1'b0);
        // tdo tied high, fixed ir_out.
        run_scan(0, 2'b11, rand_word(), 2, 2, 0, -1, 1'b0);
        // Response back-pressure for 20 cycles.
        run_scan(0, 2'b10, rand_word(), 0, -1, 20, -1, 1'b0);
        // Random scans with random hold.
        for (int r = 0; r < 3; r++)
            run_scan(0, 2'($urandom), rand_word(), 0, -1, int'($urandom_range(0, 3)), -1, 1'b0);
        // Reset during SDR bit 10.
        run_scan(0, 2'b01, rand_word(), 0, -1, 0, 4 * 2 + 10 * 4 + 1, 1'b0);
        run_scan(0, 2'b00, 38'h3F_FFFF_FFFF, 1, -1, 0, -1, 1'b0);
        // TCK_DIV=1, back-to-back with rsp_ready high.
        run_scan(1, 2'b01, rand_word(), 1, -1, 0, -1, 1'b0);
        for (int r = 0; r < 3; r++)
            run_scan(1, 2'($urandom), rand_word(), (r == 1) ? 0 : 1, -1, 0, -1, 1'b1);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/platform_nios_cpu_debug_host_scan.md
PLATFORM_NIOS_CPU_DEBUG_HOST_SCAN -- requirements
Module: platform_nios_cpu_debug_host_scan

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning clk cycles per tck half-period (legal range 1..255).
REQ-002 SHALL have parameter SR_WIDTH, default 38, meaning data-register scan length in bits.
REQ-003 SHALL have port clk  input  1  system clock; every flop is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  block idle and able to accept a command.
REQ-007 SHALL have port cmd_ir  input  2  virtual IR value to scan.
REQ-008 SHALL have port cmd_data  input  SR_WIDTH  DR word to shift in, LSB first.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  response consumed.
REQ-011 SHALL have port rsp_data  output  SR_WIDTH  DR word captured from tdo.
REQ-012 SHALL have port rsp_ir_out  output  2  ir_out sampled during the UIR phase.
REQ-013 SHALL have ports tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti: each output, 1 bit, virtual-JTAG driver signals; ir_in: output, 2 bits.
REQ-014 SHALL have port tdo  input  1  serial data from the debug slave.
REQ-015 SHALL have port ir_out  input  2  slave IR status.

Function
REQ-016 SHALL run the FSM IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> DONE -> IDLE.
REQ-017 SHALL define tck edges as follows: tck held 0 in IDLE and DONE; in all other states tck toggles every TCK_DIV clk cycles, starting low on entry to UIR.
REQ-018 SHALL make each of UIR, CDR, UDR and RTI last exactly one tck period, with transitions on tck falling-edge events.
REQ-019 SHALL make SDR last exactly SR_WIDTH tck periods.
REQ-020 SHALL accept a command when cmd_valid && cmd_ready: latch cmd_ir and cmd_data, and enter UIR on the next clk.
REQ-021 SHALL assert cmd_ready only in IDLE with rsp_valid low.
REQ-022 SHALL assert vs_uir, vs_cdr, vs_sdr, vs_udr and jtag_state_rti for the full duration of states UIR, CDR, SDR, UDR and RTI respectively; exactly one (or none) is high at any time.
REQ-023 SHALL drive ir_in with the latched cmd_ir from UIR through RTI, and 0 otherwise.
REQ-024 SHALL sample ir_out into rsp_ir_out on the rising tck edge within UIR.
REQ-025 SHALL drive tdi = data bit 0 on SDR entry, then advance to the next bit on each SDR tck falling edge; tdi is 0 outside SDR.
REQ-026 SHALL sample tdo on each SDR tck rising edge, shifting right into the MSB, so that rsp_data[i] = tdo at rising edge i (i = 0..SR_WIDTH-1).
REQ-027 SHALL in DONE assert rsp_valid and hold rsp_data and rsp_ir_out stable until rsp_ready is seen high.
REQ-028 SHALL return to IDLE with rsp_valid low on the clk after rsp_ready is seen high; if rsp_ready is already high in DONE, rsp_valid lasts one cycle.
REQ-029 SHALL assert rsp_valid exactly (4 + SR_WIDTH) * 2 * TCK_DIV clk cycles after the accept edge (168 cycles at defaults).
REQ-030 SHALL ignore cmd_valid while busy; cmd_data changes after acceptance have no effect.

Reset
REQ-031 SHALL force the following on reset_n low, immediately and asynchronously: FSM=IDLE; tck, tdi, ir_in, all vs_* and jtag_state_rti, rsp_valid=0; rsp_data=0; rsp_ir_out=0; divider and bit counters=0.
REQ-032 SHALL abort a reset asserted mid-scan with no vs_udr pulse, and SHALL NOT produce a response for the aborted command.
REQ-033 SHALL have cmd_ready high in the first cycle after reset_n deasserts.

Verification
REQ-034 Loopback (tdo=tdi), TCK_DIV=2, cmd_ir=2'b01, cmd_data=38'h15_5555_5555 -> rsp_valid 168 cycles after accept, rsp_data=38'h15_5555_5555.
REQ-035 tdo tied 1, ir_out=2'b10 -> rsp_data=38'h3F_FFFF_FFFF, rsp_ir_out=2'b10; vs_sdr high exactly 152 clk cycles.
REQ-036 rsp_ready held 0 for 20 cycles in DONE -> rsp_valid and rsp_data stable for all 20 cycles, cmd_ready low, tck 0; second cmd_valid not accepted.
REQ-037 reset_n pulsed low at SDR bit 10 -> all outputs 0 within the same cycle, no vs_udr, no rsp_valid, cmd_ready=1 after release.
REQ-038 TCK_DIV=1, back-to-back commands with rsp_ready=1 -> tck period 2 clk, accept-to-rsp_valid 84 cycles, next accept 2 cycles after rsp_valid.
REQ-039 Protocol checker on all scans -> vs_* mutually exclusive; tdi changes only on tck falling edges; tck held 0 whenever the FSM is in IDLE.
